decode_trace_aligner: RTL and testbench

- Bench-side stage directly upstream of the decoder scoreboard in TOP_CORE verification.
- Buffers the DUT decode stream and the golden-model decode stream independently; these arrive with differing, variable latency.
- Pops one entry from each stream in order and presents time-aligned pairs on a single out_valid strobe, which drives the scoreboard's valid/dut_*/gold_* inputs.
- Flags PC misalignment, FIFO overflow and stalled (orphaned) streams.

---
 rtl/decode_trace_aligner_if.sv | 69 ++++++
 rtl/decode_trace_aligner.sv | 204 ++++++++++++++++++++
 tb/tb_decode_trace_aligner.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_trace_aligner_if.sv
// Bundle of the two decode input streams, the flush control and the aligned
// pair / status outputs of decode_trace_aligner.
interface decode_trace_aligner_if #(
    parameter int CNT_W = 32
);
    logic              flush;

    logic              dut_valid;
    logic [31:0]       dut_pc;
    logic [4:0]        dut_rd;
    logic [4:0]        dut_rs1;
    logic [4:0]        dut_rs2;
    logic [31:0]       dut_imm;
    logic [31:0]       dut_instruction;
    logic [63:0]       dut_Single_Instruction;

    logic              gold_valid;
    logic [31:0]       gold_pc;
    logic [4:0]        gold_rd;
    logic [4:0]        gold_rs1;
    logic [4:0]        gold_rs2;
    logic [31:0]       gold_imm;
    logic [63:0]       gold_Single_Instruction;

    logic              out_valid;
    logic [31:0]       out_pc;
    logic [4:0]        out_dut_rd;
    logic [4:0]        out_dut_rs1;
    logic [4:0]        out_dut_rs2;
    logic [31:0]       out_dut_imm;
    logic [31:0]       out_dut_instruction;
    logic [63:0]       out_dut_Single_Instruction;
    logic [4:0]        out_gold_rd;
    logic [4:0]        out_gold_rs1;
    logic [4:0]        out_gold_rs2;
    logic [31:0]       out_gold_imm;
    logic [63:0]       out_gold_Single_Instruction;
    logic              out_pc_mismatch;
    logic              overflow;
    logic              timeout;
    logic [CNT_W-1:0]  pair_count;
    logic [CNT_W-1:0]  drop_count;

    modport slave (
        input  flush,
        input  dut_valid, dut_pc, dut_rd, dut_rs1, dut_rs2, dut_imm,
               dut_instruction, dut_Single_Instruction,
        input  gold_valid, gold_pc, gold_rd, gold_rs1, gold_rs2, gold_imm,
               gold_Single_Instruction,
        output out_valid, out_pc, out_dut_rd, out_dut_rs1, out_dut_rs2,
               out_dut_imm, out_dut_instruction, out_dut_Single_Instruction,
        output out_gold_rd, out_gold_rs1, out_gold_rs2, out_gold_imm,
               out_gold_Single_Instruction,
        output out_pc_mismatch, overflow, timeout, pair_count, drop_count
    );

    modport master (
        output flush,
        output dut_valid, dut_pc, dut_rd, dut_rs1, dut_rs2, dut_imm,
               dut_instruction, dut_Single_Instruction,
        output gold_valid, gold_pc, gold_rd, gold_rs1, gold_rs2, gold_imm,
               gold_Single_Instruction,
        input  out_valid, out_pc, out_dut_rd, out_dut_rs1, out_dut_rs2,
               out_dut_imm, out_dut_instruction, out_dut_Single_Instruction,
        input  out_gold_rd, out_gold_rs1, out_gold_rs2, out_gold_imm,
               out_gold_Single_Instruction,
        input  out_pc_mismatch, overflow, timeout, pair_count, drop_count
    );
endinterface

// File: rtl/decode_trace_aligner.sv
// Buffers the DUT and golden decode streams in independent FIFOs and emits
// one time-aligned pair per cycle when both have an entry, flagging stalls.
module decode_trace_aligner #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_trace_aligner_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] instr;
        logic [63:0] si;
    } dut_entry_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [63:0] si;
    } gold_data_t;

    typedef struct packed {
        logic [31:0] pc;
        gold_data_t  data;
    } gold_entry_t;

    dut_entry_t         dut_mem_q [DEPTH];
    gold_entry_t        gold_mem_q [DEPTH];

    logic [PTR_W-1:0]   dut_wr_ptr_q, dut_wr_ptr_d, dut_rd_ptr_q, dut_rd_ptr_d;
    logic [PTR_W-1:0]   gold_wr_ptr_q, gold_wr_ptr_d, gold_rd_ptr_q, gold_rd_ptr_d;
    logic [OCC_W-1:0]   dut_occ_q, dut_occ_d, gold_occ_q, gold_occ_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               overflow_q, overflow_d, timeout_q, timeout_d;
    logic [CNT_W-1:0]   pair_count_q, pair_count_d, drop_count_q, drop_count_d;
    logic               out_valid_q, out_valid_d, out_mismatch_q, out_mismatch_d;
    dut_entry_t         out_dut_q, out_dut_d;
    gold_data_t         out_gold_q, out_gold_d;

    dut_entry_t         dut_in_s, dut_head_s;
    gold_entry_t        gold_in_s, gold_head_s;
    logic               dut_empty_s, gold_empty_s, dut_full_s, gold_full_s;
    logic               pop_s, dut_push_s, gold_push_s, dut_drop_s, gold_drop_s;

    // Handshake decode: a full FIFO still accepts a push when it pops that edge.
    always_comb begin
        dut_in_s        = '{pc: bus.dut_pc, rd: bus.dut_rd, rs1: bus.dut_rs1,
                            rs2: bus.dut_rs2, imm: bus.dut_imm,
                            instr: bus.dut_instruction, si: bus.dut_Single_Instruction};
        gold_in_s       = '{pc: bus.gold_pc,
                            data: '{rd: bus.gold_rd, rs1: bus.gold_rs1, rs2: bus.gold_rs2,
                                    imm: bus.gold_imm, si: bus.gold_Single_Instruction}};
        dut_head_s      = dut_mem_q[dut_rd_ptr_q];
        gold_head_s     = gold_mem_q[gold_rd_ptr_q];
        dut_empty_s     = (dut_occ_q == '0);
        gold_empty_s    = (gold_occ_q == '0);
        dut_full_s      = (dut_occ_q == OCC_FULL);
        gold_full_s     = (gold_occ_q == OCC_FULL);
        pop_s           = !bus.flush && !dut_empty_s && !gold_empty_s;
        dut_push_s      = bus.dut_valid && !bus.flush && (!dut_full_s || pop_s);
        gold_push_s     = bus.gold_valid && !bus.flush && (!gold_full_s || pop_s);
        dut_drop_s      = bus.dut_valid && !bus.flush && dut_full_s && !pop_s;
        gold_drop_s     = bus.gold_valid && !bus.flush && gold_full_s && !pop_s;
    end

    // Next-state for pointers, occupancy, stall counter, status and output pair.
    always_comb begin
        dut_wr_ptr_d   = dut_wr_ptr_q;
        dut_rd_ptr_d   = dut_rd_ptr_q;
        dut_occ_d      = dut_occ_q;
        gold_wr_ptr_d  = gold_wr_ptr_q;
        gold_rd_ptr_d  = gold_rd_ptr_q;
        gold_occ_d     = gold_occ_q;
        to_cnt_d       = to_cnt_q;
        out_dut_d      = out_dut_q;
        out_gold_d     = out_gold_q;
        out_mismatch_d = out_mismatch_q;
        out_valid_d    = pop_s;
        overflow_d     = overflow_q | dut_drop_s | gold_drop_s;
        pair_count_d   = pair_count_q + CNT_W'(pop_s);
        drop_count_d   = drop_count_q + CNT_W'(dut_drop_s) + CNT_W'(gold_drop_s);

        if (bus.flush) begin
            dut_wr_ptr_d  = '0;
            dut_rd_ptr_d  = '0;
            dut_occ_d     = '0;
            gold_wr_ptr_d = '0;
            gold_rd_ptr_d = '0;
            gold_occ_d    = '0;
        end else begin
            dut_wr_ptr_d  = dut_wr_ptr_q + PTR_W'(dut_push_s);
            dut_rd_ptr_d  = dut_rd_ptr_q + PTR_W'(pop_s);
            dut_occ_d     = dut_occ_q + OCC_W'(dut_push_s) - OCC_W'(pop_s);
            gold_wr_ptr_d = gold_wr_ptr_q + PTR_W'(gold_push_s);
            gold_rd_ptr_d = gold_rd_ptr_q + PTR_W'(pop_s);
            gold_occ_d    = gold_occ_q + OCC_W'(gold_push_s) - OCC_W'(pop_s);
        end

        // Falling through the clear conditions means exactly one FIFO holds data.
        if (bus.flush || pop_s || (dut_empty_s && gold_empty_s)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1'b1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
        timeout_d = timeout_q | (to_cnt_d == TO_MAX);

        if (pop_s) begin
            out_dut_d      = dut_head_s;
            out_gold_d     = gold_head_s.data;
            out_mismatch_d = (dut_head_s.pc != gold_head_s.pc);
        end else begin
            out_mismatch_d = 1'b0;
        end
    end

    // FIFO storage, written only at the write pointer of an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dut_mem_q[i]  <= '0;
                gold_mem_q[i] <= '0;
            end
        end else begin
            if (dut_push_s) begin
                dut_mem_q[dut_wr_ptr_q] <= dut_in_s;
            end
            if (gold_push_s) begin
                gold_mem_q[gold_wr_ptr_q] <= gold_in_s;
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_wr_ptr_q   <= '0;
            dut_rd_ptr_q   <= '0;
            dut_occ_q      <= '0;
            gold_wr_ptr_q  <= '0;
            gold_rd_ptr_q  <= '0;
            gold_occ_q     <= '0;
            to_cnt_q       <= '0;
            overflow_q     <= 1'b0;
            timeout_q      <= 1'b0;
            pair_count_q   <= '0;
            drop_count_q   <= '0;
            out_valid_q    <= 1'b0;
            out_mismatch_q <= 1'b0;
            out_dut_q      <= '0;
            out_gold_q     <= '0;
        end else begin
            dut_wr_ptr_q   <= dut_wr_ptr_d;
            dut_rd_ptr_q   <= dut_rd_ptr_d;
            dut_occ_q      <= dut_occ_d;
            gold_wr_ptr_q  <= gold_wr_ptr_d;
            gold_rd_ptr_q  <= gold_rd_ptr_d;
            gold_occ_q     <= gold_occ_d;
            to_cnt_q       <= to_cnt_d;
            overflow_q     <= overflow_d;
            timeout_q      <= timeout_d;
            pair_count_q   <= pair_count_d;
            drop_count_q   <= drop_count_d;
            out_valid_q    <= out_valid_d;
            out_mismatch_q <= out_mismatch_d;
            out_dut_q      <= out_dut_d;
            out_gold_q     <= out_gold_d;
        end
    end

    assign bus.out_valid                   = out_valid_q;
    assign bus.out_pc                      = out_dut_q.pc;
    assign bus.out_dut_rd                  = out_dut_q.rd;
    assign bus.out_dut_rs1                 = out_dut_q.rs1;
    assign bus.out_dut_rs2                 = out_dut_q.rs2;
    assign bus.out_dut_imm                 = out_dut_q.imm;
    assign bus.out_dut_instruction         = out_dut_q.instr;
    assign bus.out_dut_Single_Instruction  = out_dut_q.si;
    assign bus.out_gold_rd                 = out_gold_q.rd;
    assign bus.out_gold_rs1                = out_gold_q.rs1;
    assign bus.out_gold_rs2                = out_gold_q.rs2;
    assign bus.out_gold_imm                = out_gold_q.imm;
    assign bus.out_gold_Single_Instruction = out_gold_q.si;
    assign bus.out_pc_mismatch             = out_mismatch_q;
    assign bus.overflow                    = overflow_q;
    assign bus.timeout                     = timeout_q;
    assign bus.pair_count                  = pair_count_q;
    assign bus.drop_count                  = drop_count_q;
endmodule

// File: tb/tb_decode_trace_aligner.sv
// Directed self-checking bench for decode_trace_aligner (DEPTH=16, TIMEOUT=10).
module tb_decode_trace_aligner;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

    typedef struct {
        logic [31:0] pc;
        logic        mm;
        logic [4:0]  drd;
        logic [4:0]  grd;
        logic [31:0] dimm;
        logic [31:0] gimm;
        logic [31:0] dinstr;
        logic [63:0] dsi;
        logic [63:0] gsi;
        int          cyc;
    } rec_t;
    rec_t recs[$];

    decode_trace_aligner_if #(.CNT_W(32)) bus ();

    decode_trace_aligner #(.DEPTH(16), .TIMEOUT(10), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field generators: DUT and golden streams use different encodings per PC.
    function automatic logic [31:0] d_imm(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [31:0] g_imm(input logic [31:0] pc);
        return pc + 32'h0000_1000;
    endfunction
    function automatic logic [63:0] d_si(input logic [31:0] pc);
        return {pc, ~pc};
    endfunction
    function automatic logic [63:0] g_si(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_dut(input bit v, input logic [31:0] pc);
        bus.dut_valid              = v;
        bus.dut_pc                 = pc;
        bus.dut_rd                 = pc[6:2];
        bus.dut_rs1                = pc[11:7];
        bus.dut_rs2                = ~pc[6:2];
        bus.dut_imm                = d_imm(pc);
        bus.dut_instruction        = {pc[15:0], 16'h0033};
        bus.dut_Single_Instruction = d_si(pc);
    endtask

    task automatic drive_gold(input bit v, input logic [31:0] pc);
        bus.gold_valid              = v;
        bus.gold_pc                 = pc;
        bus.gold_rd                 = pc[6:2] ^ 5'h1F;
        bus.gold_rs1                = pc[11:7];
        bus.gold_rs2                = pc[6:2];
        bus.gold_imm                = g_imm(pc);
        bus.gold_Single_Instruction = g_si(pc);
    endtask

    task automatic idle_inputs();
        bus.flush = 1'b0;
        drive_dut(1'b0, 32'h0);
        drive_gold(1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            rec_t r;
            r.pc     = bus.out_pc;
            r.mm     = bus.out_pc_mismatch;
            r.drd    = bus.out_dut_rd;
            r.grd    = bus.out_gold_rd;
            r.dimm   = bus.out_dut_imm;
            r.gimm   = bus.out_gold_imm;
            r.dinstr = bus.out_dut_instruction;
            r.dsi    = bus.out_dut_Single_Instruction;
            r.gsi    = bus.out_gold_Single_Instruction;
            r.cyc    = cyc;
            recs.push_back(r);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        recs.delete();
    endtask

    initial begin
        int          push_cyc;
        logic [31:0] p;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_pc", bus.out_pc, 32'h0);
        check_eq("rst_overflow", bus.overflow, 1'b0);
        check_eq("rst_timeout", bus.timeout, 1'b0);
        check_eq("rst_pair_count", bus.pair_count, 32'd0);
        check_eq("rst_drop_count", bus.drop_count, 32'd0);
        rst_n = 1'b1;
        tick();
        recs.delete();

        // Lockstep: five entries on both streams on the same cycles
        push_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            p = 32'(i * 4);
            drive_dut(1'b1, p);
            drive_gold(1'b1, p);
            tick();
            if (i == 0) push_cyc = cyc;
        end
        idle_inputs();
        repeat (3) tick();
        check_eq("lock_npairs", recs.size(), 5);
        for (int i = 0; i < recs.size() && i < 5; i++) begin
            p = 32'(i * 4);
            check_eq("lock_pc", recs[i].pc, p);
            check_eq("lock_mm", recs[i].mm, 1'b0);
            check_eq("lock_cycle", recs[i].cyc - push_cyc, i + 1);
        end
        check_eq("lock_pair_count", bus.pair_count, 32'd5);

        // Skew: golden lags the DUT by six cycles
        do_reset();
        for (int t = 0; t < 14; t++) begin
            drive_dut(t < 8, 32'h200 + 32'(t * 4));
            drive_gold(t >= 6, (t >= 6) ? 32'h200 + 32'((t - 6) * 4) : 32'h0);
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        check_eq("skew_npairs", recs.size(), 8);
        for (int i = 0; i < recs.size() && i < 8; i++) begin
            p = 32'h200 + 32'(i * 4);
            check_eq("skew_pc", recs[i].pc, p);
            check_eq("skew_mm", recs[i].mm, 1'b0);
            check_eq("skew_dut_imm", recs[i].dimm, d_imm(p));
            check_eq("skew_gold_imm", recs[i].gimm, g_imm(p));
            check_eq("skew_gold_rd", recs[i].grd, p[6:2] ^ 5'h1F);
            check_eq("skew_dut_si", recs[i].dsi, d_si(p));
            check_eq("skew_gold_si", recs[i].gsi, g_si(p));
            check_eq("skew_dut_instr", recs[i].dinstr, {p[15:0], 16'h0033});
        end
        check_eq("skew_timeout", bus.timeout, 1'b0);
        check_eq("skew_pair_count", bus.pair_count, 32'd8);

        // Overflow: 18 DUT pushes into a 16-deep FIFO, then golden catches up
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive_dut(1'b1, 32'h300 + 32'(i * 4));
            tick();
        end
        idle_inputs();
        tick();
        check_eq("ovf_flag", bus.overflow, 1'b1);
        check_eq("ovf_drop_count", bus.drop_count, 32'd2);
        check_eq("ovf_no_pairs", recs.size(), 0);
        for (int i = 0; i < 16; i++) begin
            drive_gold(1'b1, 32'h300 + 32'(i * 4));
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        check_eq("ovf_npairs", recs.size(), 16);
        for (int i = 0; i < recs.size() && i < 16; i++) begin
            p = 32'h300 + 32'(i * 4);
            check_eq("ovf_pc", recs[i].pc, p);
            check_eq("ovf_mm", recs[i].mm, 1'b0);
        end
        check_eq("ovf_drop_hold", bus.drop_count, 32'd2);

        // PC mismatch in one pair
        do_reset();
        drive_dut(1'b1, 32'h100);
        drive_gold(1'b1, 32'h104);
        tick();
        idle_inputs();
        repeat (3) tick();
        check_eq("mm_npairs", recs.size(), 1);
        if (recs.size() > 0) begin
            check_eq("mm_flag", recs[0].mm, 1'b1);
            check_eq("mm_pc", recs[0].pc, 32'h100);
            check_eq("mm_gold_imm", recs[0].gimm, g_imm(32'h104));
        end
        check_eq("mm_strobe_len", bus.out_valid, 1'b0);
        check_eq("mm_flag_clear", bus.out_pc_mismatch, 1'b0);

        // Timeout: one orphan DUT entry, limit reached on the 10th stall edge
        do_reset();
        drive_dut(1'b1, 32'h400);
        tick();
        idle_inputs();
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq($sformatf("to_after_%0d", k), bus.timeout, (k >= 10) ? 1'b1 : 1'b0);
        end
        bus.flush = 1'b1;
        drive_dut(1'b1, 32'h444);
        tick();
        idle_inputs();
        check_eq("flush_out_valid", bus.out_valid, 1'b0);
        check_eq("flush_timeout_sticky", bus.timeout, 1'b1);
        check_eq("flush_no_drop", bus.drop_count, 32'd0);
        check_eq("flush_no_ovf", bus.overflow, 1'b0);
        drive_gold(1'b1, 32'h500);
        tick();
        idle_inputs();
        repeat (2) tick();
        check_eq("flush_dut_empty", recs.size(), 0);
        drive_dut(1'b1, 32'h500);
        tick();
        idle_inputs();
        repeat (2) tick();
        check_eq("postflush_npairs", recs.size(), 1);
        if (recs.size() > 0) begin
            check_eq("postflush_pc", recs[0].pc, 32'h500);
            check_eq("postflush_mm", recs[0].mm, 1'b0);
        end

        // Asynchronous reset with three DUT entries buffered
        do_reset();
        drive_dut(1'b1, 32'h600);
        drive_gold(1'b1, 32'h600);
        tick();
        idle_inputs();
        tick();
        check_eq("ar_pre_pairs", bus.pair_count, 32'd1);
        check_eq("ar_pre_pc", bus.out_pc, 32'h600);
        for (int i = 0; i < 3; i++) begin
            drive_dut(1'b1, 32'h610 + 32'(i * 4));
            tick();
        end
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_out_pc", bus.out_pc, 32'h0);
        check_eq("ar_pair_count", bus.pair_count, 32'd0);
        check_eq("ar_out_dut_imm", bus.out_dut_imm, 32'h0);
        check_eq("ar_out_valid", bus.out_valid, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        recs.delete();
        drive_dut(1'b1, 32'h700);
        drive_gold(1'b1, 32'h700);
        tick();
        idle_inputs();
        repeat (2) tick();
        check_eq("ar_post_pairs", bus.pair_count, 32'd1);
        check_eq("ar_post_npairs", recs.size(), 1);
        if (recs.size() > 0) begin
            check_eq("ar_post_pc", recs[0].pc, 32'h700);
            check_eq("ar_post_mm", recs[0].mm, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
